uart_bti_bridge: RTL

Debug bridge that turns a byte stream received over UART into BTI master transactions and returns the result as UART bytes. It is the initiator counterpart of the BTI-slave UART peripheral: it sits between a `uart_rx`/`uart_tx` pair and a BTI request/response port, so an external host can read and write any BTI-mapped address over a serial line. The block handles one transaction at a time, with an inter-byte timeout for resynchronisation.

---
 rtl/bti_pkg.sv | 23 ++
 rtl/uart_bti_bridge_pkg.sv | 24 ++
 rtl/bti_if.sv | 19 +
 rtl/uart_bti_bridge_to.sv | 30 +++
 rtl/uart_bti_bridge.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bti_pkg.sv
// Shared BTI bus types: command encoding and request/response packet layouts.
package bti_pkg;

    localparam int BTI_ADDR_W = 32;
    localparam int BTI_DATA_W = 32;

    typedef enum logic [1:0] {
        BTI_CMD_READ  = 2'd0,
        BTI_CMD_WRITE = 2'd1
    } bti_cmd_e;

    typedef struct packed {
        bti_cmd_e              cmd;
        logic [BTI_ADDR_W-1:0] addr;
        logic [BTI_DATA_W-1:0] data;
    } bti_req_pkt_t;

    typedef struct packed {
        logic                  ok;
        logic [BTI_DATA_W-1:0] data;
    } bti_rsp_pkt_t;

endpackage

// File: rtl/uart_bti_bridge_pkg.sv
// Wire-format constants, FSM state encoding and a byte-lane helper for the UART-to-BTI bridge.
package uart_bti_bridge_pkg;

    localparam logic [7:0] UB_OP_WR  = 8'h57;
    localparam logic [7:0] UB_OP_RD  = 8'h52;
    localparam logic [7:0] UB_ST_OK  = 8'h4B;
    localparam logic [7:0] UB_ST_ERR = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_REQ    = 3'd3,
        S_RSP    = 3'd4,
        S_TX_STS = 3'd5,
        S_TX_DAT = 3'd6
    } ub_state_e;

    // Little-endian byte lane idx of a 32-bit word.
    function automatic logic [7:0] ub_byte_sel(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

endpackage

// File: rtl/bti_if.sv
// BTI request and response channels. Handshake: a transfer happens on a rising clock edge
// where vld and rdy are both high; once vld is raised, it and pkt stay stable until that edge.
interface bti_req_if_t;
    logic                  vld;
    logic                  rdy;
    bti_pkg::bti_req_pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
    logic                  vld;
    logic                  rdy;
    bti_pkg::bti_rsp_pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/uart_bti_bridge_to.sv
// Inter-byte timeout: counts idle cycles while enabled and flags expiry on the limit-th one.
module uart_bti_bridge_to #(
    parameter int TO_W = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic [TO_W-1:0] limit,
    output logic            expire
);

    logic [TO_W-1:0] count;
    logic            at_last;

    // A zero limit never expires; a clear in the same cycle (new byte) always wins.
    assign at_last = (count == limit - 1'b1);
    assign expire  = enable && !clear && (limit != '0) && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_bti_bridge.sv
// UART byte stream to BTI master bridge: decodes read/write frames, issues one BTI
// transaction, and returns a status byte (plus read data) one byte at a time.
module uart_bti_bridge
    import bti_pkg::*;
    import uart_bti_bridge_pkg::*;
#(
    parameter int BTI_AW = 32,
    parameter int BTI_DW = 32,
    parameter int TO_W   = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TO_W-1:0] to_cyc,
    input  logic            rx_ch_vld,
    input  logic [7:0]      rx_ch,
    output logic            tx_ch_vld,
    output logic [7:0]      tx_ch,
    input  logic            tx_done,
    bti_req_if_t.mst        bti_req_mst,
    bti_rsp_if_t.slv        bti_rsp_slv,
    output logic            busy,
    output ub_state_e       dbg_state
);

    ub_state_e         state, state_nxt;
    logic              wr_q;
    logic [1:0]        cnt_q;
    logic [BTI_AW-1:0] addr_q;
    logic [BTI_DW-1:0] data_q;
    logic              ok_q;
    logic [BTI_DW-1:0] rdata_q;
    logic              tx_vld_q;
    logic [7:0]        tx_ch_q;

    logic              is_op;
    logic              to_expire;
    logic              op_take, cnt_clr, cnt_inc, addr_shift, data_shift, rsp_take;
    logic              tx_load, req_vld, rsp_rdy, to_en;
    logic [7:0]        tx_byte;

    assign is_op = rx_ch_vld && ((rx_ch == UB_OP_WR) || (rx_ch == UB_OP_RD));

    uart_bti_bridge_to #(.TO_W(TO_W)) u_to (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_ch_vld || !to_en),
        .enable (to_en),
        .limit  (to_cyc),
        .expire (to_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (is_op) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (to_expire)                         state_nxt = S_IDLE;
                else if (rx_ch_vld && cnt_q == 2'd3)   state_nxt = wr_q ? S_DATA : S_REQ;
            end
            S_DATA: begin
                if (to_expire)                         state_nxt = S_IDLE;
                else if (rx_ch_vld && cnt_q == 2'd3)   state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bti_req_mst.rdy) state_nxt = S_RSP;
            end
            S_RSP: begin
                if (bti_rsp_slv.vld) state_nxt = S_TX_STS;
            end
            S_TX_STS: begin
                if (tx_done) state_nxt = (wr_q || !ok_q) ? S_IDLE : S_TX_DAT;
            end
            S_TX_DAT: begin
                if (tx_done && cnt_q == 2'd3) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        op_take    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        rsp_take   = 1'b0;
        tx_load    = 1'b0;
        tx_byte    = 8'h00;
        req_vld    = 1'b0;
        rsp_rdy    = 1'b0;
        to_en      = 1'b0;
        case (state)
            S_IDLE: begin
                op_take = is_op;
                cnt_clr = is_op;
            end
            S_ADDR: begin
                to_en      = 1'b1;
                addr_shift = rx_ch_vld;
                cnt_inc    = rx_ch_vld;
            end
            S_DATA: begin
                to_en      = 1'b1;
                data_shift = rx_ch_vld;
                cnt_inc    = rx_ch_vld;
            end
            S_REQ: begin
                req_vld = 1'b1;
            end
            S_RSP: begin
                rsp_rdy = 1'b1;
                if (bti_rsp_slv.vld) begin
                    rsp_take = 1'b1;
                    cnt_clr  = 1'b1;
                    tx_load  = 1'b1;
                    tx_byte  = bti_rsp_slv.pkt.ok ? UB_ST_OK : UB_ST_ERR;
                end
            end
            S_TX_STS: begin
                if (tx_done && !wr_q && ok_q) begin
                    tx_load = 1'b1;
                    tx_byte = ub_byte_sel(rdata_q, 2'd0);
                end
            end
            S_TX_DAT: begin
                if (tx_done) begin
                    cnt_inc = 1'b1;
                    if (cnt_q != 2'd3) begin
                        tx_load = 1'b1;
                        tx_byte = ub_byte_sel(rdata_q, cnt_q + 2'd1);
                    end
                end
            end
            default: begin
                op_take = 1'b0;
            end
        endcase
    end

    // The byte counter is shared: address/data lane select while receiving, read-data lane while replying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            data_q   <= '0;
            ok_q     <= 1'b0;
            rdata_q  <= '0;
            tx_vld_q <= 1'b0;
            tx_ch_q  <= 8'h00;
        end else begin
            if (op_take) wr_q <= (rx_ch == UB_OP_WR);
            if (cnt_clr)      cnt_q <= 2'd0;
            else if (cnt_inc) cnt_q <= cnt_q + 2'd1;
            if (addr_shift) addr_q[8*cnt_q +: 8] <= rx_ch;
            if (data_shift) data_q[8*cnt_q +: 8] <= rx_ch;
            if (rsp_take) begin
                ok_q    <= bti_rsp_slv.pkt.ok;
                rdata_q <= bti_rsp_slv.pkt.data;
            end
            tx_vld_q <= tx_load;
            if (tx_load) tx_ch_q <= tx_byte;
        end
    end

    assign bti_req_mst.vld = req_vld;
    assign bti_req_mst.pkt = '{
        cmd:  wr_q ? BTI_CMD_WRITE : BTI_CMD_READ,
        addr: addr_q,
        data: wr_q ? data_q : '0
    };
    assign bti_rsp_slv.rdy = rsp_rdy;

    assign tx_ch_vld = tx_vld_q;
    assign tx_ch     = tx_ch_q;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
